// File: rtl/seq_count_pkg.sv
// Shared types and defaults for the sequential counter family.
package seq_count_pkg;

  localparam int SEQ_COUNT_NBITS = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } seq_count_state_e;

endpackage : seq_count_pkg

// File: rtl/seq_count_reg_ld_en.sv
// Resettable nbits register: synchronous clear to zero takes priority over load of d.
module seq_count_reg_ld_en
  import seq_count_pkg::*;
#(
  parameter int nbits = SEQ_COUNT_NBITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             ld,
  input  logic [nbits-1:0] d,
  output logic [nbits-1:0] q
);

  logic [nbits-1:0] q_r;

  // Storage: async reset, then clear > load > hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r <= {nbits{1'b0}};
    end else if (clr) begin
      q_r <= {nbits{1'b0}};
    end else if (ld) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule : seq_count_reg_ld_en

// File: rtl/seq_count_bin_var_up.sv
// Loadable binary up-counter: counts from 0 to a captured terminal value, then flags done.
// Define SEQ_COUNT_VAR_UP_WRAP_EN for free-running modulo-(limit+1) counting.
module seq_count_bin_var_up
  import seq_count_pkg::*;
#(
  parameter int nbits = SEQ_COUNT_NBITS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld,
  input  logic [nbits-1:0] in_,
  input  logic             en,
  output logic [nbits-1:0] out,
  output logic             done
);

  seq_count_state_e state_r;
  logic             done_r;
  logic [nbits-1:0] count_r;
  logic [nbits-1:0] limit_r;
  logic [nbits-1:0] count_inc_s;
  logic             step_s;
  logic             wrap_s;

  seq_count_reg_ld_en #(.nbits(nbits)) u_count (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (ld | wrap_s),
    .ld      (step_s),
    .d       (count_inc_s),
    .q       (count_r)
  );

  seq_count_reg_ld_en #(.nbits(nbits)) u_limit (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (1'b0),
    .ld      (ld),
    .d       (in_),
    .q       (limit_r)
  );

  // Next-count decode: a load overrides enable; only COUNT (or DONE when wrapping) advances.
  always_comb begin
    count_inc_s = count_r + {{(nbits-1){1'b0}}, 1'b1};
    step_s      = 1'b0;
    wrap_s      = 1'b0;
    if (ld) begin
      step_s = 1'b0;
    end else if (en) begin
      case (state_r)
        COUNT: step_s = 1'b1;
`ifdef SEQ_COUNT_VAR_UP_WRAP_EN
        DONE:  wrap_s = 1'b1;
`else
        DONE:  wrap_s = 1'b0;
`endif
        default: step_s = 1'b0;
      endcase
    end else begin
      step_s = 1'b0;
    end
  end

  // Control FSM with registered done flag, kept in lockstep with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      done_r  <= 1'b1;
    end else if (ld) begin
      if (in_ == {nbits{1'b0}}) begin
        state_r <= DONE;
        done_r  <= 1'b1;
      end else begin
        state_r <= COUNT;
        done_r  <= 1'b0;
      end
    end else if (step_s && (count_inc_s == limit_r)) begin
      state_r <= DONE;
      done_r  <= 1'b1;
    end else if (wrap_s && (limit_r != {nbits{1'b0}})) begin
      // A zero limit keeps the wrapped counter parked in DONE at 0.
      state_r <= COUNT;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_r;
      done_r  <= done_r;
    end
  end

  assign out  = count_r;
  assign done = done_r;

endmodule : seq_count_bin_var_up

// File: tb/tb_seq_count_bin_var_up.sv
// Directed and model-checked bench for seq_count_bin_var_up (both wrap builds).
module tb_seq_count_bin_var_up;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ld;
  logic [2:0] in_;
  logic       en;
  logic [2:0] out;
  logic       done;

  int checks = 0;
  int errors = 0;

  seq_count_bin_var_up #(.nbits(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ld      (ld),
    .in_     (in_),
    .en      (en),
    .out     (out),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ld = 1'b0; en = 1'b0; in_ = 3'd0;
    tick(); tick();
    checks++;
    if (out !== 3'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset: got out=%0d done=%0b expected out=0 done=1", out, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b1;
    tick();
    checks++;
    if (out !== 3'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_en: got out=%0d done=%0b expected out=0 done=1", out, done);
    end
    en = 1'b0;
  endtask

  task automatic test_load_zero();
    ld = 1'b1; in_ = 3'd0; en = 1'b1;
    tick();
    ld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out !== 3'd0 || done !== 1'b1) begin
        errors++;
        $display("FAIL load_zero[%0d]: got out=%0d done=%0b expected out=0 done=1", i, out, done);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_count4();
    ld = 1'b1; in_ = 3'd4; en = 1'b0;
    tick();
    checks++;
    if (out !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL count4_load: got out=%0d done=%0b expected out=0 done=0", out, done);
    end
    ld = 1'b0; en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (out !== 3'(i) || done !== (i == 4)) begin
        errors++;
        $display("FAIL count4_step: got out=%0d done=%0b expected out=%0d done=%0b", out, done, i, (i == 4));
      end
    end
`ifdef SEQ_COUNT_VAR_UP_WRAP_EN
    en = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out !== 3'd4 || done !== 1'b1) begin
        errors++;
        $display("FAIL count4_hold: got out=%0d done=%0b expected out=4 done=1", out, done);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_count7_pause();
    logic [2:0] exp_out;
    ld = 1'b1; in_ = 3'd7; en = 1'b1;
    tick();
    ld = 1'b0;
    // Nine edges after load: three counting, two paused, four counting.
    for (int i = 1; i <= 9; i++) begin
      en = !(i == 4 || i == 5);
      tick();
      exp_out = (i <= 3) ? 3'(i) : (i <= 5) ? 3'd3 : 3'(i - 2);
      checks++;
      if (out !== exp_out || done !== (i == 9)) begin
        errors++;
        $display("FAIL count7_pause[%0d]: got out=%0d done=%0b expected out=%0d done=%0b", i, out, done, exp_out, (i == 9));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reload();
    ld = 1'b1; in_ = 3'd5; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1;
    tick(); tick();
    checks++;
    if (out !== 3'd2) begin
      errors++;
      $display("FAIL reload_pre: got out=%0d expected out=2", out);
    end
    ld = 1'b1; in_ = 3'd3;
    tick();
    checks++;
    if (out !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reload_restart: got out=%0d done=%0b expected out=0 done=0", out, done);
    end
    ld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (out !== 3'(i) || done !== (i == 3)) begin
        errors++;
        $display("FAIL reload_step: got out=%0d done=%0b expected out=%0d done=%0b", out, done, i, (i == 3));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    ld = 1'b1; in_ = 3'd5; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (out !== 3'd3) begin
      errors++;
      $display("FAIL async_pre: got out=%0d expected out=3", out);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out !== 3'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got out=%0d done=%0b expected out=0 done=1", out, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 3'd0 || done !== 1'b1) begin
        errors++;
        $display("FAIL async_idle: got out=%0d done=%0b expected out=0 done=1", out, done);
      end
    end
    ld = 1'b1; in_ = 3'd2;
    tick();
    ld = 1'b0;
    tick();
    checks++;
    if (out !== 3'd1 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_resume: got out=%0d done=%0b expected out=1 done=0", out, done);
    end
    en = 1'b0;
  endtask

`ifdef SEQ_COUNT_VAR_UP_WRAP_EN
  task automatic test_wrap();
    logic [2:0] seq [6];
    seq = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    ld = 1'b1; in_ = 3'd2; en = 1'b0;
    tick();
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out !== seq[i] || done !== (seq[i] == 3'd2)) begin
        errors++;
        $display("FAIL wrap[%0d]: got out=%0d done=%0b expected out=%0d done=%0b", i, out, done, seq[i], (seq[i] == 3'd2));
      end
    end
    en = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [2:0] m_count;
    logic [2:0] m_limit;
    int         m_state;
    reset_n = 1'b0; ld = 1'b0; en = 1'b0;
    #2;
    @(negedge clk);
    reset_n = 1'b1;
    m_count = 3'd0; m_limit = 3'd0; m_state = 0;
    for (int i = 0; i < 50; i++) begin
      ld  = (i == 0) || ($urandom_range(0, 7) == 0);
      in_ = 3'($urandom_range(0, 7));
      en  = ($urandom_range(0, 3) != 0);
      tick();
      if (ld) begin
        m_limit = in_;
        m_count = 3'd0;
        m_state = (in_ == 3'd0) ? 2 : 1;
      end else if (en && m_state == 1) begin
        m_count = m_count + 3'd1;
        if (m_count == m_limit) m_state = 2;
      end else if (en && m_state == 2) begin
`ifdef SEQ_COUNT_VAR_UP_WRAP_EN
        m_count = 3'd0;
        m_state = (m_limit == 3'd0) ? 2 : 1;
`endif
      end
      checks++;
      if (out !== m_count || done !== (m_state != 1)) begin
        errors++;
        $display("FAIL random[%0d]: got out=%0d done=%0b expected out=%0d done=%0b", i, out, done, m_count, (m_state != 1));
      end
    end
    ld = 1'b0; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_zero();
    test_count4();
    test_count7_pause();
    test_reload();
    test_async_reset();
`ifdef SEQ_COUNT_VAR_UP_WRAP_EN
    test_wrap();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seq_count_bin_var_up
